// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle for the PC sequencer: next-PC select inputs and PC/RAS status outputs.
// Control has no valid/ready pair: every non-stalled cycle accepts pc_sel, stall=1 is a hold.
interface pc_sequencer_if #(
  parameter int W         = 32,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4,
  parameter int CW        = $clog2(RAS_DEPTH + 1)
);
  logic             stall;
  logic [2:0]       pc_sel;
  logic             take;
  logic [W-1:0]     rs;
  logic [IMM_W-1:0] imm;
  logic [W-1:0]     pc;
  logic [W-1:0]     incr_pc;
  logic             redirect;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, pc_sel, take, rs, imm,
    input  pc, incr_pc, redirect, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, pc_sel, take, rs, imm,
    output pc, incr_pc, redirect, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter for the fetch stage with next-PC selection and a circular
// return-address stack for CALL/RET.
module pc_sequencer #(
  parameter int           W         = 32,
  parameter int           IMM_W     = 16,
  parameter int           INCR      = 4,
  parameter int           RAS_DEPTH = 4,
  parameter logic [W-1:0] RESET_VEC = '0
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] SEL_BR   = 3'b001;
  localparam logic [2:0] SEL_JR   = 3'b010;
  localparam logic [2:0] SEL_JABS = 3'b011;
  localparam logic [2:0] SEL_CALL = 3'b100;
  localparam logic [2:0] SEL_RET  = 3'b101;

  logic [W-1:0]  r_pc;
  logic          r_redirect;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_top;
  logic          r_overflow;
  logic          r_underflow;
  logic [W-1:0]  r_ras [RAS_DEPTH];

  logic [W-1:0]  w_incr_pc;
  logic [W-1:0]  w_sext;
  logic [W-1:0]  w_off;
  logic [W-1:0]  w_next_pc;
  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_top_inc;
  logic [PW-1:0] w_top_dec;
  logic          w_ras_full;
  logic          w_ras_empty;

  assign w_incr_pc   = r_pc + W'(INCR);
  assign w_sext      = {{(W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
  assign w_off       = w_sext << 2;
  assign w_top_inc   = (r_top == PW'(RAS_DEPTH - 1)) ? '0 : r_top + 1'b1;
  assign w_top_dec   = (r_top == '0) ? PW'(RAS_DEPTH - 1) : r_top - 1'b1;
  assign w_ras_full  = (r_count == CW'(RAS_DEPTH));
  assign w_ras_empty = (r_count == '0);

  always_comb begin
    w_next_pc  = w_incr_pc;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    case (bus.pc_sel)
      SEL_BR: begin
        if (bus.take) begin
          w_next_pc  = w_incr_pc + w_off;
          w_redirect = 1'b1;
        end
      end
      SEL_JR: begin
        w_next_pc  = bus.rs;
        w_redirect = 1'b1;
      end
      SEL_JABS: begin
        w_next_pc  = {r_pc[W-1:IMM_W+2], bus.imm, 2'b00};
        w_redirect = 1'b1;
      end
      SEL_CALL: begin
        w_next_pc  = w_incr_pc + w_off;
        w_redirect = 1'b1;
        w_push     = 1'b1;
      end
      SEL_RET: begin
        w_next_pc  = w_ras_empty ? RESET_VEC : r_ras[r_top];
        w_redirect = 1'b1;
        w_pop      = 1'b1;
      end
      default: ;
    endcase
  end

  // A push always advances the top pointer; when full this lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_VEC;
      r_redirect  <= 1'b0;
      r_count     <= '0;
      r_top       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!bus.stall) begin
      r_pc       <= w_next_pc;
      r_redirect <= w_redirect;
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_ras_full) r_overflow <= 1'b1;
        else            r_count    <= r_count + 1'b1;
      end else if (w_pop) begin
        if (w_ras_empty) begin
          r_underflow <= 1'b1;
        end else begin
          r_count <= r_count - 1'b1;
          r_top   <= w_top_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && w_push) r_ras[w_top_inc] <= w_incr_pc;
  end

  assign bus.pc            = r_pc;
  assign bus.incr_pc       = w_incr_pc;
  assign bus.redirect      = r_redirect;
  assign bus.ras_count     = r_count;
  assign bus.ras_overflow  = r_overflow;
  assign bus.ras_underflow = r_underflow;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-cycle vectors, then hand sequences for
// RAS overflow/unwind, stall hold and reset during a CALL.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_sequencer_if #(.W(32), .IMM_W(16), .RAS_DEPTH(4)) bus ();

  pc_sequencer #(
    .W(32), .IMM_W(16), .INCR(4), .RAS_DEPTH(4), .RESET_VEC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  sel;
    logic        take;
    logic [31:0] rs;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        redir;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [2:0] sel, input logic take, input logic [31:0] rs,
                              input logic [15:0] imm, input logic [31:0] pc, input logic redir,
                              input logic [2:0] cnt, input logic unf);
    vec_t v;
    v.stall = 1'b0; v.sel = sel; v.take = take; v.rs = rs; v.imm = imm;
    v.pc = pc; v.redir = redir; v.cnt = cnt; v.ovf = 1'b0; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic redir,
                         input logic [2:0] cnt, input logic ovf, input logic unf);
    chk({tag, " pc"}, bus.pc, pc);
    chk({tag, " incr_pc"}, bus.incr_pc, pc + 32'd4);
    chk({tag, " redirect"}, 32'(bus.redirect), 32'(redir));
    chk({tag, " ras_count"}, 32'(bus.ras_count), 32'(cnt));
    chk({tag, " ovf"}, 32'(bus.ras_overflow), 32'(ovf));
    chk({tag, " unf"}, 32'(bus.ras_underflow), 32'(unf));
  endtask

  task automatic drive(input logic stall, input logic [2:0] sel, input logic take,
                       input logic [31:0] rs, input logic [15:0] imm);
    bus.stall  = stall;
    bus.pc_sel = sel;
    bus.take   = take;
    bus.rs     = rs;
    bus.imm    = imm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] call_pc [5];
    logic [31:0] ret_pc  [4];
    total = 0;
    bad   = 0;
    call_pc = '{32'h4C, 32'h90, 32'hD4, 32'h118, 32'h15C};
    ret_pc  = '{32'h11C, 32'hD8, 32'h94, 32'h50};

    vecs[0]  = mk(3'b000, 1'b0, 32'h0,  16'h0000, 32'h4,        1'b0, 3'd0, 1'b0);
    vecs[1]  = mk(3'b000, 1'b0, 32'h0,  16'h0000, 32'h8,        1'b0, 3'd0, 1'b0);
    vecs[2]  = mk(3'b000, 1'b0, 32'h0,  16'h0000, 32'hC,        1'b0, 3'd0, 1'b0);
    vecs[3]  = mk(3'b010, 1'b0, 32'h28, 16'h0000, 32'h28,       1'b1, 3'd0, 1'b0);
    vecs[4]  = mk(3'b001, 1'b1, 32'h0,  16'h0002, 32'h34,       1'b1, 3'd0, 1'b0);
    vecs[5]  = mk(3'b010, 1'b0, 32'h28, 16'h0000, 32'h28,       1'b1, 3'd0, 1'b0);
    vecs[6]  = mk(3'b001, 1'b0, 32'h0,  16'h0005, 32'h2C,       1'b0, 3'd0, 1'b0);
    vecs[7]  = mk(3'b010, 1'b0, 32'h28, 16'h0000, 32'h28,       1'b1, 3'd0, 1'b0);
    vecs[8]  = mk(3'b001, 1'b1, 32'h0,  16'h8002, 32'hFFFE0034, 1'b1, 3'd0, 1'b0);
    vecs[9]  = mk(3'b010, 1'b0, 32'h10, 16'h0000, 32'h10,       1'b1, 3'd0, 1'b0);
    vecs[10] = mk(3'b011, 1'b0, 32'h0,  16'h0040, 32'h100,      1'b1, 3'd0, 1'b0);
    vecs[11] = mk(3'b100, 1'b0, 32'h0,  16'h0010, 32'h144,      1'b1, 3'd1, 1'b0);
    vecs[12] = mk(3'b101, 1'b0, 32'h0,  16'h0000, 32'h104,      1'b1, 3'd0, 1'b0);
    vecs[13] = mk(3'b101, 1'b0, 32'h0,  16'h0000, 32'h0,        1'b1, 3'd0, 1'b1);
    vecs[14] = mk(3'b110, 1'b1, 32'h0,  16'h0040, 32'h4,        1'b0, 3'd0, 1'b1);
    vecs[15] = mk(3'b111, 1'b1, 32'h0,  16'h0040, 32'h8,        1'b0, 3'd0, 1'b1);

    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 32'h0, 16'h0);
    drive(1'b0, 3'b000, 1'b0, 32'h0, 16'h0);
    chk_all("reset", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].sel, vecs[i].take, vecs[i].rs, vecs[i].imm);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].redir, vecs[i].cnt,
              vecs[i].ovf, vecs[i].unf);
    end

    // Five nested calls from pc=0x8 overflow a 4-deep stack.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'b100, 1'b0, 32'h0, 16'h0010);
      chk_all($sformatf("call%0d", i + 1), call_pc[i], 1'b1, (i < 4) ? 3'(i + 1) : 3'd4,
              (i == 4), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b101, 1'b0, 32'h0, 16'h0);
      chk_all($sformatf("ret%0d", i + 1), ret_pc[i], 1'b1, 3'(3 - i), 1'b1, 1'b1);
    end

    drive(1'b0, 3'b100, 1'b0, 32'h0, 16'h0010);
    chk_all("call_pre_stall", 32'h94, 1'b1, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b100, 1'b0, 32'h0, 16'h0010);
      chk_all($sformatf("stall%0d", i), 32'h94, 1'b1, 3'd1, 1'b1, 1'b1);
    end
    drive(1'b1, 3'b101, 1'b0, 32'h0, 16'h0);
    chk_all("stall_ret", 32'h94, 1'b1, 3'd1, 1'b1, 1'b1);

    rst = 1'b1;
    drive(1'b0, 3'b100, 1'b0, 32'h0, 16'h0010);
    chk_all("rst_call", 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'h0, 16'h0);
    chk_all("post_rst_seq", 32'h4, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
